// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared state encodings and defaults for the serializer and its downstream detector
package bit_serializer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  localparam logic IDLE_LEVEL_DEF = 1'b0;
  typedef enum logic [1:0] {s0 = 2'd0, s1 = 2'd1, s2 = 2'd2, s3 = 2'd3} det_state_t;
endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel word handshake in, qualified serial stream out
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic ser_out;
  logic ser_valid;
  logic busy;
  logic word_done;
  modport master (output in_data, in_valid, input in_ready, ser_out, ser_valid, busy, word_done);
  modport slave (input in_data, in_valid, output in_ready, ser_out, ser_valid, busy, word_done);
endinterface

// File: rtl/bit_counter_sat.sv
// bit_counter_sat: bit index counter that stops at WIDTH-1 and flags the last bit
module bit_counter_sat #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic [CW-1:0] count,
  output logic last
);
  assign last = count == CW'(WIDTH - 1);
  // clear wins over enable; holding at the last index keeps the count from wrapping
  always_ff @(posedge clk) begin
    if (!reset || clr) count <= '0;
    else if (en && !last) count <= count + CW'(1);
  end
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: shifts valid/ready words out one bit per clock with back-to-back reload
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input logic clk,
  input logic reset,
  bit_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic out_q, out_d, done_q, done_d;
  logic [CW-1:0] count;
  logic last, xfer, shifting;
  assign shifting = state == ST_SHIFT;
  assign bus.in_ready = reset && (!shifting || last);
  assign xfer = bus.in_valid && bus.in_ready;
  assign bus.ser_out = out_q;
  assign bus.ser_valid = shifting;
  assign bus.busy = shifting;
  assign bus.word_done = done_q;
  bit_counter_sat #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(xfer || (shifting && last)),
    .en(shifting),
    .count(count),
    .last(last)
  );
  // sreg holds the bits still to be sent; out_q is the bit currently on the line
  always_comb begin
    state_d = state;
    sreg_d = sreg;
    out_d = out_q;
    done_d = 1'b0;
    if (xfer) begin
      state_d = ST_SHIFT;
      sreg_d = MSB_FIRST ? {bus.in_data[WIDTH-2:0], 1'b0} : {1'b0, bus.in_data[WIDTH-1:1]};
      out_d = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
    end else if (shifting && last) begin
      state_d = ST_IDLE;
      sreg_d = '0;
      out_d = IDLE_LEVEL;
    end else if (shifting) begin
      sreg_d = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      out_d = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
      done_d = count == CW'(WIDTH - 2);
    end
  end
  // state and registered outputs; reset discards any partially sent word
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      sreg <= '0;
      out_q <= IDLE_LEVEL;
      done_q <= 1'b0;
    end else begin
      state <= state_d;
      sreg <= sreg_d;
      out_q <= out_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for the serializer plus a 101 detector model downstream
module tb_bit_serializer;
  import bit_serializer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [1:0] q[$];
  det_state_t det = s0;
  int det_hits = 0;
  bit_serializer_if #(.WIDTH(8)) bm ();
  bit_serializer_if #(.WIDTH(8)) bl ();
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (.clk(clk), .reset(reset), .bus(bm));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl));
  always #5 clk = ~clk;

  function automatic det_state_t det_next(det_state_t s, logic b);
    case (s)
      s0: return b ? s1 : s0;
      s1: return b ? s1 : s2;
      s2: return b ? s3 : s0;
      default: return b ? s1 : s2;
    endcase
  endfunction

  // overlapping Moore 101 detector fed by the MSB-first stream
  always @(posedge clk) begin
    if (!reset) det <= s0;
    else if (bm.ser_valid) det <= det_next(det, bm.ser_out);
  end

  // scoreboard monitor: every valid bit pops one expectation, idle cycles must be quiet
  always @(negedge clk) begin
    if (det == s3) det_hits++;
    if (!reset) begin
      checks++;
      assert (bm.in_ready === 1'b0 && bm.ser_valid === 1'b0 && bm.busy === 1'b0 && bm.word_done === 1'b0)
        else begin errors++; $error("FAIL reset_outputs: got rdy=%b val=%b busy=%b done=%b expected 0000", bm.in_ready, bm.ser_valid, bm.busy, bm.word_done); end
    end else begin
      checks++;
      assert (bm.busy === bm.ser_valid)
        else begin errors++; $error("FAIL busy: got %b expected %b", bm.busy, bm.ser_valid); end
      if (bm.ser_valid === 1'b1) begin
        checks++;
        assert (q.size() != 0)
          else begin errors++; $error("FAIL extra_bit: got valid bit %b expected no bit", bm.ser_out); end
        if (q.size() != 0) begin
          logic [1:0] exp;
          exp = q.pop_front();
          checks++;
          assert ({bm.ser_out, bm.word_done} === exp)
            else begin errors++; $error("FAIL bit: got out/done=%b expected %b", {bm.ser_out, bm.word_done}, exp); end
        end
      end else begin
        checks++;
        assert (q.size() == 0)
          else begin errors++; $error("FAIL missing_bit: got ser_valid=%b expected 1 (%0d pending)", bm.ser_valid, q.size()); end
        checks++;
        assert (bm.ser_out === 1'b0 && bm.word_done === 1'b0 && bm.in_ready === 1'b1)
          else begin errors++; $error("FAIL idle_outputs: got out=%b done=%b rdy=%b expected 0 0 1", bm.ser_out, bm.word_done, bm.in_ready); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer a word to dut_m until accepted; waits = negedges seen up to and including acceptance
  task automatic send(input logic [7:0] w, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    bm.in_data = w;
    bm.in_valid = 1'b1;
    while (!done && waits < 40) begin
      @(negedge clk);
      waits++;
      if (bm.in_ready) begin
        tick();
        for (int i = 0; i < 8; i++) q.push_back({w[7-i], i == 7});
        done = 1'b1;
      end
    end
    checks++;
    assert (done)
      else begin errors++; $error("FAIL send_timeout: got no transfer of %h expected one within 40 cycles", w); end
  endtask

  initial begin
    int waits;
    logic [7:0] lw [2];
    lw[0] = 8'h01;
    lw[1] = 8'hB4;
    bm.in_data = '0;
    bm.in_valid = 1'b0;
    bl.in_data = '0;
    bl.in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();

    // LSB-first instance, checked directly
    foreach (lw[k]) begin
      bl.in_data = lw[k];
      bl.in_valid = 1'b1;
      tick();
      bl.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        checks++;
        assert (bl.ser_valid === 1'b1 && bl.ser_out === lw[k][i] && bl.word_done === (i == 7))
          else begin errors++; $error("FAIL lsb_bit%0d: got v/o/d=%b%b%b expected 1%b%b", i, bl.ser_valid, bl.ser_out, bl.word_done, lw[k][i], i == 7); end
      end
      @(negedge clk);
      checks++;
      assert (bl.ser_valid === 1'b0 && bl.ser_out === 1'b0)
        else begin errors++; $error("FAIL lsb_end: got v/o=%b%b expected 00", bl.ser_valid, bl.ser_out); end
      tick();
    end

    // single word A5
    send(8'hA5, waits);
    bm.in_valid = 1'b0;
    repeat (12) tick();

    // back-to-back F0, 0F: the second word is accepted only on the 8th bit of the first
    send(8'hF0, waits);
    send(8'h0F, waits);
    checks++;
    assert (waits == 8)
      else begin errors++; $error("FAIL b2b_ready: got accept after %0d cycles expected 8", waits); end
    bm.in_valid = 1'b0;
    repeat (12) tick();

    // reset after 3 bits of FF: remainder discarded
    send(8'hFF, waits);
    bm.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    checks++;
    assert (bm.ser_valid === 1'b0 && bm.busy === 1'b0 && bm.ser_out === 1'b0)
      else begin errors++; $error("FAIL midword_reset: got v/b/o=%b%b%b expected 000", bm.ser_valid, bm.busy, bm.ser_out); end
    tick();
    reset = 1'b1;
    repeat (10) tick();
    send(8'h81, waits);
    bm.in_valid = 1'b0;
    repeat (12) tick();

    // serializer into the detector: 00101100 yields exactly one hit
    reset = 1'b0;
    tick();
    reset = 1'b1;
    det_hits = 0;
    send(8'b0010_1100, waits);
    bm.in_valid = 1'b0;
    repeat (14) tick();
    checks++;
    assert (det_hits == 1)
      else begin errors++; $error("FAIL detector: got %0d hit cycles expected 1", det_hits); end
    checks++;
    assert (q.size() == 0)
      else begin errors++; $error("FAIL drain: got %0d bits pending expected 0", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial converter sitting directly upstream of the sequence detector FSM. It drives that detector's single-bit data_in from parallel words.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Shifts each word out one bit per clock on ser_out, qualified by ser_valid.
- Supports back-to-back words with no idle gap.
- Outputs IDLE_LEVEL when no word is in flight, so the detector sees a defined level.

Parameters:
WIDTH, 8, bits per word (minimum 2)
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
IDLE_LEVEL, 0, value driven on ser_out while ser_valid = 0

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (0 = reset asserted)
in_data  in  WIDTH  parallel word to serialize
in_valid  in  1  in_data is valid this cycle
in_ready  out  1  block accepts a word this cycle (transfer = in_valid & in_ready)
ser_out  out  1  serial bit stream (feeds the detector's data_in)
ser_valid  out  1  ser_out carries a payload bit this cycle
busy  out  1  a word is in flight (state SHIFT)
word_done  out  1  one-cycle pulse registered with the last bit of each word

Behaviour:
- Reset (reset = 0 at posedge clk) takes priority over everything, including mid-word:
  - state = IDLE, shift register = 0, bit counter = 0.
  - ser_valid = 0, ser_out = IDLE_LEVEL, busy = 0, word_done = 0.
  - A partially sent word is discarded and never resumed.
- in_ready is combinational: 1 in IDLE; 1 in SHIFT only when bit counter == WIDTH-1 (last bit); 0 during reset.
- States: IDLE and SHIFT.
- IDLE, on transfer:
  - Load in_data into the shift register; bit counter = 0; go to SHIFT.
  - The first bit appears on ser_out with ser_valid = 1 in the cycle after the transfer (latency 1 clock).
- IDLE, no transfer: hold; ser_out = IDLE_LEVEL.
- SHIFT:
  - ser_out = shift register MSB (MSB_FIRST = 1) or LSB (MSB_FIRST = 0); ser_valid = 1.
  - Each clock: shift by one toward the output end, counter += 1.
- Last bit (counter == WIDTH-1):
  - word_done = 1 in the same cycle as that bit.
  - If a transfer occurs that cycle: reload, counter = 0, stay in SHIFT. No gap bit; ser_valid stays 1 continuously.
  - Otherwise: go to IDLE; ser_valid = 0 next cycle.
- in_valid while in_ready = 0: ignored. The word must be held by the upstream producer (standard valid/ready; no internal buffering).
- Counter width is clog2(WIDTH); the counter never wraps past WIDTH-1.
- Output registering:
  - ser_out, ser_valid and word_done are registered.
  - in_ready is the only combinational output.
- Throughput: one bit per clock; sustained back-to-back words at 100 % bit utilisation.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
  - the IDLE_LEVEL default;
  - the detector state constants s0..s3, so testbenches can check serializer + detector together.
- One natural sub-module, bit_counter_sat: a clog2(WIDTH)-bit counter with clear, enable and a last flag (count == WIDTH-1). Everything else lives in the top module.

Test Plan:
- Reset then idle: hold reset = 0 for 3 clocks, then release with in_valid = 0 for 5 clocks -> ser_valid = 0, ser_out = 0, busy = 0, in_ready = 1 every cycle.
- Single word, MSB_FIRST = 1, WIDTH = 8: in_data = 8'hA5 for one transfer -> starting next cycle, ser_out = 1,0,1,0,0,1,0,1 with ser_valid = 1 for exactly 8 cycles; word_done = 1 on the 8th bit only; then ser_valid = 0.
- Back-to-back: 8'hF0 then 8'h0F, with in_valid held high -> in_ready = 1 only on the last bit of the first word; 16 contiguous valid bits 11110000 00001111; word_done pulses at bits 8 and 16.
- LSB-first: MSB_FIRST = 0, in_data = 8'h01 -> ser_out = 1,0,0,0,0,0,0,0.
- Reset mid-word: send 8'hFF, assert reset = 0 after 3 bits -> next cycle ser_valid = 0, busy = 0, and the remaining 5 bits are never emitted; after release, 8'h81 serializes cleanly.
- System with detector: send 8'b0010_1100 MSB-first into the detector -> detector output data_out = 1 for exactly one cycle, after the 1,0,1 pattern at bits 3-5.
